// File: rtl/nn_neuron_mac_if.sv
// Handshake and configuration bundle between a neuron MAC and its controller.
// The slave modport is the neuron's view; master is the driver's view.
interface nn_neuron_mac_if #(
    parameter int dataWidth = 16,
    parameter int numInputs = 784
) ();
    localparam int AW = $clog2(numInputs + 1);

    logic                        start;
    logic                        ren;
    logic                        in_valid;
    logic signed [dataWidth-1:0] in_data;
    logic                        in_last;
    logic                        w_wen;
    logic [AW-1:0]               w_addr;
    logic signed [dataWidth-1:0] w_data;
    logic                        busy;
    logic                        out_valid;
    logic signed [dataWidth-1:0] out_data;
    logic                        err;

    modport slave (
        input  start, in_valid, in_data, in_last, w_wen, w_addr, w_data,
        output ren, busy, out_valid, out_data, err
    );

    modport master (
        output start, in_valid, in_data, in_last, w_wen, w_addr, w_data,
        input  ren, busy, out_valid, out_data, err
    );
endinterface

// File: rtl/nn_neuron_mac.sv
// Single fixed-point neuron: weighted sum of streamed samples, plus bias, ReLU with
// saturation. Weights and bias live in a small register store writable only when idle.
//
//   state | meaning
//   IDLE  | waiting for start; weight/bias writes accepted
//   ACCUM | ren high, multiplying samples by weights and accumulating
//   DRAIN | two cycles letting the last registered product reach the accumulator
//   BIAS  | accumulator plus scaled bias registered into acc_b
//   ACT   | two cycles; the second presents the activated result and returns to IDLE
module nn_neuron_mac #(
    parameter int dataWidth = 16,
    parameter int fracBits  = 8,
    parameter int numInputs = 784
) (
    input  logic             clk,
    input  logic             rst_n,
    nn_neuron_mac_if.slave   bus_if
);
    localparam int AW    = $clog2(numInputs + 1);
    localparam int PW    = 2 * dataWidth;
    localparam int ACC_W = PW + $clog2(numInputs);
    localparam int BW    = ACC_W + 1;

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, BIAS, ACT} state_t;

    state_t state_q, state_d;
    logic   phase_q, phase_d;

    logic signed [dataWidth-1:0] mem_q [numInputs+1];
    logic signed [PW-1:0]        prod_q;
    logic                        prod_vld_q;
    logic signed [ACC_W-1:0]     acc_q;
    logic signed [BW-1:0]        acc_b_q;
    logic [AW-1:0]               cnt_q;
    logic                        ren_q;
    logic                        err_q;
    logic                        out_valid_q;
    logic signed [dataWidth-1:0] out_data_q;

    logic                        take, take_last, accept;
    logic signed [PW-1:0]        a_ext, w_ext, prod_d;
    logic signed [dataWidth-1:0] w_rd, bias_rd, act_val;
    logic signed [BW-1:0]        shifted;

    assign take      = (state_q == ACCUM) && bus_if.in_valid;
    assign take_last = take && bus_if.in_last;
    assign accept    = take && (cnt_q < AW'(numInputs));

    assign w_rd    = mem_q[cnt_q];
    assign bias_rd = mem_q[AW'(numInputs)];
    assign a_ext   = {{dataWidth{bus_if.in_data[dataWidth-1]}}, bus_if.in_data};
    assign w_ext   = {{dataWidth{w_rd[dataWidth-1]}}, w_rd};
    assign prod_d  = a_ext * w_ext;
    assign shifted = acc_b_q >>> fracBits;

    always_comb begin
        act_val = shifted[dataWidth-1:0];
        if (shifted[BW-1]) begin
            act_val = '0;
        end else if (|shifted[BW-2:dataWidth-1]) begin
            act_val = {1'b0, {(dataWidth-1){1'b1}}};
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = 1'b0;
        case (state_q)
            IDLE:    if (bus_if.start) state_d = ACCUM;
            ACCUM:   if (take_last) state_d = DRAIN;
            DRAIN: begin
                phase_d = ~phase_q;
                if (phase_q) state_d = BIAS;
            end
            BIAS:    state_d = ACT;
            ACT: begin
                phase_d = ~phase_q;
                if (phase_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // Weight store deliberately has no reset so weights survive an aborted inference.
    always_ff @(posedge clk) begin
        if ((state_q == IDLE) && bus_if.w_wen && (bus_if.w_addr <= AW'(numInputs))) begin
            mem_q[bus_if.w_addr] <= bus_if.w_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q      <= '0;
            prod_vld_q  <= 1'b0;
            acc_q       <= '0;
            acc_b_q     <= '0;
            cnt_q       <= '0;
            ren_q       <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            prod_vld_q  <= 1'b0;
            out_valid_q <= 1'b0;
            if ((state_q == IDLE) && bus_if.start) begin
                acc_q <= '0;
                cnt_q <= '0;
                err_q <= 1'b0;
                ren_q <= 1'b1;
            end
            if (accept) begin
                prod_q     <= prod_d;
                prod_vld_q <= 1'b1;
                cnt_q      <= cnt_q + 1'b1;
            end
            if (take && !accept) err_q <= 1'b1;
            if (take_last) begin
                ren_q <= 1'b0;
                if (cnt_q != AW'(numInputs - 1)) err_q <= 1'b1;
            end
            if (prod_vld_q) begin
                acc_q <= acc_q + {{(ACC_W-PW){prod_q[PW-1]}}, prod_q};
            end
            if (state_q == BIAS) begin
                acc_b_q <= {acc_q[ACC_W-1], acc_q}
                         + {{(BW-dataWidth-fracBits){bias_rd[dataWidth-1]}}, bias_rd, {fracBits{1'b0}}};
            end
            if ((state_q == ACT) && phase_q) begin
                out_valid_q <= 1'b1;
                out_data_q  <= act_val;
            end
        end
    end

    assign bus_if.ren       = ren_q;
    assign bus_if.busy      = (state_q != IDLE);
    assign bus_if.out_valid = out_valid_q;
    assign bus_if.out_data  = out_data_q;
    assign bus_if.err       = err_q;
endmodule

// File: tb/tb_nn_neuron_mac.sv
// Directed bench for nn_neuron_mac (4 inputs, Q8.8): stimulus pushes expected results,
// a negedge monitor pops and compares them whenever out_valid is seen.
module tb_nn_neuron_mac;
    localparam int DW = 16;
    localparam int FB = 8;
    localparam int N  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    nn_neuron_mac_if #(.dataWidth(DW), .numInputs(N)) bus ();

    nn_neuron_mac #(.dataWidth(DW), .fracBits(FB), .numInputs(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus)
    );

    typedef struct {
        logic [15:0] d;
        logic        e;
        int          c;
    } exp_t;

    exp_t sb_q[$];
    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        nvec++;
        if (act !== exp_v) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_out_valid: got out_data %h, expected no result", bus.out_data);
            end else begin
                e = sb_q.pop_front();
                chk("out_data", bus.out_data, e.d);
                chk("err", bus.err, e.e);
                chk("out_valid_edge", cyc, e.c);
            end
        end
    end

    task automatic wr(input int a, input logic [15:0] d);
        @(posedge clk); #1;
        bus.w_wen  = 1'b1;
        bus.w_addr = 3'(a);
        bus.w_data = d;
        @(posedge clk); #1;
        bus.w_wen  = 1'b0;
    endtask

    task automatic load(input logic [15:0] w, input logic [15:0] b);
        for (int i = 0; i < N; i++) wr(i, w);
        wr(N, b);
    endtask

    // ns samples of value x; pulses = start/bias-write during ACCUM; wr0 = weight[0]
    // written in the start cycle; gap_at = insert an in_valid=0 cycle before that sample.
    task automatic run(input int ns, input logic [15:0] x, input logic [15:0] ed, input logic ee,
                       input bit pulses, input bit wr0, input int gap_at);
        @(posedge clk); #1;
        bus.start = 1'b1;
        if (wr0) begin
            bus.w_wen  = 1'b1;
            bus.w_addr = 3'd0;
            bus.w_data = 16'h0200;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.w_wen = 1'b0;
        chk("ren_accum", bus.ren, 1);
        chk("busy_accum", bus.busy, 1);
        chk("err_cleared", bus.err, 0);
        for (int i = 0; i < ns; i++) begin
            if (i == gap_at) begin
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b1;
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = x;
            bus.in_last  = (i == ns - 1);
            if (pulses && i == 1) begin
                bus.start  = 1'b1;
                bus.w_wen  = 1'b1;
                bus.w_addr = 3'(N);
                bus.w_data = 16'h7000;
            end
            if (i == ns - 1) sb_q.push_back('{ed, ee, cyc + 1 + 5});
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.w_wen = 1'b0;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("ren_after_last", bus.ren, 0);
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("result_seen", sb_q.size(), 0);
        sb_q.delete();
        chk("busy_idle", bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        bus.w_wen    = 1'b0;
        bus.w_addr   = '0;
        bus.w_data   = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ren", bus.ren, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_err", bus.err, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        load(16'h0100, 16'h0080);
        run(4, 16'h0100, 16'h0480, 1'b0, 0, 0, -1);

        load(16'hFF00, 16'h0000);
        run(4, 16'h0100, 16'h0000, 1'b0, 0, 0, -1);

        load(16'h6400, 16'h0000);
        run(4, 16'h6400, 16'h7FFF, 1'b0, 0, 0, -1);

        load(16'h0100, 16'h0000);
        run(2, 16'h0100, 16'h0200, 1'b1, 0, 0, -1);
        repeat (3) @(posedge clk);
        #1;
        chk("err_holds", bus.err, 1);
        chk("out_data_holds", bus.out_data, 16'h0200);

        // Abort mid-inference, then rerun with the retained weights.
        wr(N, 16'h0080);
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0100;
        repeat (2) begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ren", bus.ren, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_out_data", bus.out_data, 0);
        chk("abort_err", bus.err, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (8) @(posedge clk);
        run(4, 16'h0100, 16'h0480, 1'b0, 0, 0, -1);

        run(4, 16'h0100, 16'h0480, 1'b0, 1, 0, -1);
        run(4, 16'h0100, 16'h0480, 1'b0, 0, 0, -1);

        run(5, 16'h0100, 16'h0480, 1'b1, 0, 0, -1);

        run(4, 16'h0100, 16'h0580, 1'b0, 0, 1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/nn_neuron_mac.md
NN_NEURON_MAC -- requirements
Module: nn_neuron_mac

Interface
REQ-001 Parameter dataWidth, default 16, signed width of input samples, weights, bias and output.
REQ-002 Parameter fracBits, default 8, fractional bits of the fixed-point format shared by data, weights, bias and output.
REQ-003 Parameter numInputs, default 784, inputs per inference and depth of the weight store.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle request to run one inference.
REQ-007 ren  output  1  read enable to the upstream input memory.
REQ-008 in_valid  input  1  upstream sample valid.
REQ-009 in_data  input  dataWidth  upstream sample, signed.
REQ-010 in_last  input  1  marks the final upstream sample; qualified by in_valid.
REQ-011 w_wen  input  1  weight/bias write strobe.
REQ-012 w_addr  input  $clog2(numInputs+1)  write address; 0..numInputs-1 = weights, numInputs = bias.
REQ-013 w_data  input  dataWidth  weight or bias value, signed.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 out_valid  output  1  single-cycle result strobe.
REQ-016 out_data  output  dataWidth  activated neuron output, signed, always >= 0.
REQ-017 err  output  1  sample-count mismatch flag for the last inference.

Function
REQ-018 FSM states IDLE, ACCUM, DRAIN, BIAS, ACT; reset state IDLE.
REQ-019 IDLE -> ACCUM on start=1; the edge sampling start clears accumulator, sample counter and err.
REQ-020 start is ignored outside IDLE.
REQ-021 ren is 1 in ACCUM only: set by the edge leaving IDLE, cleared by the edge sampling in_valid&in_last.
REQ-022 in_valid is ignored outside ACCUM; no back-pressure; every valid sample in ACCUM is consumed.
REQ-023 Sample k (k = counter value, 0-based) is multiplied by weight[k]; full-precision product (2*dataWidth bits) is registered (stage 1).
REQ-024 Registered product is added to a signed accumulator of 2*dataWidth+$clog2(numInputs) bits the next edge (stage 2); no overflow is possible at this width.
REQ-025 ACCUM -> DRAIN on in_valid&in_last; DRAIN lasts 2 cycles so the last product is accumulated.
REQ-026 Counter saturates at numInputs; samples beyond numInputs are not accumulated and set err.
REQ-027 in_last with counter+1 != numInputs sets err; inference still completes with the samples received.
REQ-028 BIAS: acc_b = accumulator + (bias sign-extended, shifted left by fracBits), registered.
REQ-029 ACT: acc_b arithmetic-shifted right by fracBits (truncation toward minus infinity); negative -> 0 (ReLU); above 2^(dataWidth-1)-1 -> saturate to that value.
REQ-030 out_valid is 1 for exactly one cycle, 5 edges after the edge sampling in_valid&in_last; state returns to IDLE on that same edge.
REQ-031 out_data holds its value until the next result; err holds until the next start is accepted.
REQ-032 Weight/bias writes are accepted only in IDLE; w_wen outside IDLE or w_addr > numInputs is dropped.
REQ-033 Write with start in the same IDLE cycle: write commits and applies to that inference.
REQ-034 Weight store contents are undefined after power-up and unaffected by rst_n.

Reset
REQ-035 rst_n=0 forces, asynchronously: state IDLE, ren=0, busy=0, out_valid=0, out_data=0, err=0, accumulator, product register and counter = 0.
REQ-036 Reset mid-inference aborts with no out_valid; the next start runs a fresh inference with retained weights.

Verification (numInputs=4, dataWidth=16, fracBits=8)
REQ-037 Weights 0x0100 x4, bias 0x0080, inputs 0x0100 x4 with in_last on 4th -> out_data=0x0480, out_valid 5 edges after last, err=0.
REQ-038 Weights 0xFF00 (-1.0) x4, bias 0, inputs 0x0100 x4 -> out_data=0x0000 (ReLU), err=0.
REQ-039 Weights 0x6400 x4, inputs 0x6400 x4, bias 0 -> out_data=0x7FFF (saturation).
REQ-040 in_last on 2nd sample, weights/inputs 0x0100, bias 0 -> out_data=0x0200, err=1; ren drops on that edge.
REQ-041 rst_n pulsed low after 2 samples -> all outputs 0 immediately, no out_valid; rerun of REQ-037 stimulus gives 0x0480.
REQ-042 start and w_wen pulsed during ACCUM -> ignored; result and stored weights unchanged.
